// File: rtl/board_io_pkg.sv
// Shared constants for the board I/O conditioning blocks: debounce FSM encoding
// and debounce window lengths.
package board_io_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_e;

  // 10 ms at 50 MHz; the short value keeps simulations fast.
  localparam int STABLE_CYCLES_50MHZ = 500000;
  localparam int STABLE_CYCLES_SIM   = 4;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Board button bundle: raw bouncy pins toward the debouncer, clean level and
// press/release strobes back toward user logic.
interface btn_debounce_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] btn_raw;
  logic [WIDTH-1:0] btn_level;
  logic [WIDTH-1:0] btn_press;
  logic [WIDTH-1:0] btn_release;

  modport master (output btn_raw, input btn_level, btn_press, btn_release);
  modport slave  (input btn_raw, output btn_level, btn_press, btn_release);
endinterface

// File: rtl/btn_debounce_ch.sv
// One debounce channel: two-flop synchronizer, stability counter, two-state
// FSM and registered press/release strobes.
module btn_debounce_ch
  import board_io_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_50MHZ
) (
  input  logic mclk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int            CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  state_e        r_state, w_state_nxt;
  logic          r_sync1, r_sync2;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_level, w_level_nxt;
  logic          r_press, w_press_nxt;
  logic          r_release, w_release_nxt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, exactly like the hardware.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_state   <= ST_STABLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;

    case (r_state)
      ST_STABLE: begin
        w_cnt_nxt = '0;
        if (r_sync2 != r_level) begin
          w_state_nxt = ST_CHECK;
          w_cnt_nxt   = CW'(1);
        end
      end
      ST_CHECK: begin
        if (r_sync2 == r_level) begin
          // Bounced back before the window closed: drop the candidate.
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = ST_STABLE;
          w_cnt_nxt     = '0;
          w_level_nxt   = r_sync2;
          w_press_nxt   = r_sync2;
          w_release_nxt = ~r_sync2;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/btn_debounce.sv
// Debounces WIDTH independent board inputs into the mclk domain; this level
// only replicates the single-channel conditioner across the bus.
module btn_debounce
  import board_io_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = STABLE_CYCLES_50MHZ
) (
  input  logic           mclk,
  input  logic           rst,
  btn_debounce_if.slave  bus
);

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_press;
  logic [WIDTH-1:0] w_release;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .mclk      (mclk),
      .rst       (rst),
      .i_raw     (bus.btn_raw[g]),
      .o_level   (w_level[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g])
    );
  end

  assign bus.btn_level   = w_level;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_release;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: a window-based reference model predicts
// level and strobes each edge; a negedge monitor compares the DUT against it.
module tb_btn_debounce;
  import board_io_pkg::*;

  localparam int W = 4;
  localparam int S = STABLE_CYCLES_SIM;

  typedef struct packed {
    logic [W-1:0] level;
    logic [W-1:0] press;
    logic [W-1:0] rel;
  } obs_t;

  logic mclk = 1'b0;
  logic rst  = 1'b0;

  btn_debounce_if #(.WIDTH(W)) bus ();

  btn_debounce #(
    .WIDTH         (W),
    .STABLE_CYCLES (S)
  ) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 mclk = ~mclk;

  int n_cmp = 0;
  int n_bad = 0;
  int obs_press_cnt[W];
  int obs_rel_cnt[W];

  obs_t         exp_q[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] m_level;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < S + 2; k++) hist.push_back('0);
    m_level = '0;
    exp_q.delete();
  endtask

  // Reference model: the value raw had at edge j reaches the debouncer's
  // decision at edge j+2. A channel flips at edge t when the raw samples of
  // edges t-S-1 .. t-2 (S consecutive cycles) all differ from its level.
  initial begin
    model_reset();
    forever begin
      @(posedge mclk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        obs_t e;
        e = '0;
        hist.push_back(bus.btn_raw);
        while (hist.size() > S + 2) void'(hist.pop_front());
        for (int c = 0; c < W; c++) begin
          bit all_diff;
          all_diff = 1'b1;
          for (int k = 0; k < S; k++)
            if (hist[k][c] == m_level[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_level[c] = ~m_level[c];
            if (m_level[c]) e.press[c] = 1'b1;
            else            e.rel[c]   = 1'b1;
          end
        end
        e.level = m_level;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: outputs are registered, so every negedge shows one edge's result.
  initial begin
    for (int c = 0; c < W; c++) begin
      obs_press_cnt[c] = 0;
      obs_rel_cnt[c]   = 0;
    end
    forever begin
      @(negedge mclk);
      for (int c = 0; c < W; c++) begin
        if (bus.btn_press[c])   obs_press_cnt[c]++;
        if (bus.btn_release[c]) obs_rel_cnt[c]++;
      end
      if (rst || exp_q.size() == 0) begin
        check("idle_outputs", {20'd0, bus.btn_level, bus.btn_press, bus.btn_release}, 32'd0);
      end else begin
        obs_t e;
        e = exp_q.pop_front();
        check("level",   32'(bus.btn_level),   32'(e.level));
        check("press",   32'(bus.btn_press),   32'(e.press));
        check("release", 32'(bus.btn_release), 32'(e.rel));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic snap(output int p[W], output int r[W]);
    for (int c = 0; c < W; c++) begin
      p[c] = obs_press_cnt[c];
      r[c] = obs_rel_cnt[c];
    end
  endtask

  initial begin
    int p0[W];
    int r0[W];
    logic [W-1:0] raw;

    raw = '0;
    bus.btn_raw = '0;
    #1 rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;

    // Reset / idle
    wait_cycles(20);
    #1 check("idle_level", 32'(bus.btn_level), 32'd0);

    // Clean press on channel 0, held long: exactly one press, no release
    snap(p0, r0);
    @(negedge mclk); raw[0] = 1'b1; bus.btn_raw = raw;
    wait_cycles(20);
    #1 check("press0_level", 32'(bus.btn_level[0]), 32'd1);
    check("press0_once", 32'(obs_press_cnt[0] - p0[0]), 32'd1);
    check("press0_no_release", 32'(obs_rel_cnt[0] - r0[0]), 32'd0);

    // Bounce on channel 1: highs of 1, 2, 3 cycles separated by 1-cycle lows
    snap(p0, r0);
    for (int len = 1; len <= 3; len++) begin
      @(negedge mclk); raw[1] = 1'b1; bus.btn_raw = raw;
      wait_cycles(len - 1);
      @(negedge mclk); raw[1] = 1'b0; bus.btn_raw = raw;
    end
    wait_cycles(15);
    #1 check("bounce1_level", 32'(bus.btn_level[1]), 32'd0);
    check("bounce1_no_strobe", 32'(obs_press_cnt[1] - p0[1] + obs_rel_cnt[1] - r0[1]), 32'd0);

    // Release on channel 2 after establishing level 1
    @(negedge mclk); raw[2] = 1'b1; bus.btn_raw = raw;
    wait_cycles(12);
    snap(p0, r0);
    @(negedge mclk); raw[2] = 1'b0; bus.btn_raw = raw;
    wait_cycles(12);
    #1 check("release2_level", 32'(bus.btn_level[2]), 32'd0);
    check("release2_once", 32'(obs_rel_cnt[2] - r0[2]), 32'd1);

    // Simultaneous: 0000 -> 1111
    @(negedge mclk); raw = '0; bus.btn_raw = raw;
    wait_cycles(12);
    snap(p0, r0);
    @(negedge mclk); raw = '1; bus.btn_raw = raw;
    wait_cycles(15);
    #1 check("simul_level", 32'(bus.btn_level), 32'hf);
    for (int c = 0; c < W; c++)
      check($sformatf("simul_press_once_%0d", c), 32'(obs_press_cnt[c] - p0[c]), 32'd1);

    // Reset mid-check on channel 3
    @(negedge mclk); raw = '0; bus.btn_raw = raw;
    wait_cycles(12);
    @(negedge mclk); raw[3] = 1'b1; bus.btn_raw = raw;
    wait_cycles(3);
    @(posedge mclk); #2 rst = 1'b1;
    #1 check("rst_async_clear", {20'd0, bus.btn_level, bus.btn_press, bus.btn_release}, 32'd0);
    #1 rst = 1'b0;
    snap(p0, r0);
    wait_cycles(15);
    #1 check("rst_recover_level3", 32'(bus.btn_level[3]), 32'd1);
    check("rst_recover_press3", 32'(obs_press_cnt[3] - p0[3]), 32'd1);

    // Randomized phases: alternating heavy bounce and slow toggling,
    // with occasional asynchronous reset pulses between edges.
    for (int ph = 0; ph < 20; ph++) begin
      int p;
      p = (ph % 2 == 1) ? 2 : 8;
      for (int cyc = 0; cyc < 100; cyc++) begin
        @(negedge mclk);
        for (int c = 0; c < W; c++)
          if ($urandom_range(p - 1) == 0) raw[c] = ~raw[c];
        bus.btn_raw = raw;
        if ($urandom_range(299) == 0) begin
          #2 rst = 1'b1;
          #2 rst = 1'b0;
        end
      end
    end
    wait_cycles(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
